// File: rtl/ula_seq.sv
// ula_seq: registered, valid/ready-handshaked add/sub/logic/shift/accumulate unit.
// One operation in flight at a time; result held in HOLD until consumed.
// Optional feature macro: ULA_SEQ_MUL_EN adds an iterative shift-add multiplier
// (opcode 111, BUSY state). Without it, opcode 111 completes in one cycle with s=0, ovf=1.
//
//  state | meaning
//  IDLE  | waiting for an operation, in_ready=1
//  HOLD  | result presented, out_valid=1 until out_ready
//  BUSY  | multiplier iterating, one partial product per cycle (MUL builds only)
module ula_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_s,
    output logic             ovf,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ULA_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
    localparam int CW = $clog2(WIDTH + 1);
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t state, state_nxt, accept_dest;

    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   acc_full;
    logic [WIDTH-1:0] sub_res;
    logic [2*WIDTH-1:0] shl_full;

`ifdef ULA_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
`endif

    assign accept = in_valid & in_ready;
    assign zero   = (output_s == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept_dest = HOLD;
`ifdef ULA_SEQ_MUL_EN
        if (op == OP_MUL) accept_dest = BUSY;
`endif
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = accept_dest;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? accept_dest : IDLE;
            end
`ifdef ULA_SEQ_MUL_EN
            BUSY: begin
                if (cnt == CW'(1)) state_nxt = HOLD;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result computed straight from the offered operands.
    always_comb begin
        add_full = {1'b0, input_a} + {1'b0, input_b};
        sub_res  = input_a - input_b;
        shl_full = {{WIDTH{1'b0}}, input_a} << input_b[SHW-1:0];
        acc_full = {1'b0, acc} + {1'b0, input_a};
        res      = '0;
        res_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                res     = add_full[WIDTH-1:0];
                res_ovf = add_full[WIDTH];
            end
            OP_SUB: begin
                res     = sub_res;
                res_ovf = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (sub_res[WIDTH-1] != input_a[WIDTH-1]);
            end
            OP_AND: res = input_a & input_b;
            OP_OR:  res = input_a | input_b;
            OP_XOR: res = input_a ^ input_b;
            OP_SHL: begin
                res     = shl_full[WIDTH-1:0];
                res_ovf = |shl_full[2*WIDTH-1:WIDTH];
            end
            OP_ACC: begin
                res     = acc_full[WIDTH-1:0];
                res_ovf = acc_full[WIDTH];
            end
`ifndef ULA_SEQ_MUL_EN
            OP_MUL: begin
                res     = '0;
                res_ovf = 1'b1;
            end
`endif
            default: begin
                res     = '0;
                res_ovf = 1'b0;
            end
        endcase
    end

`ifdef ULA_SEQ_MUL_EN
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
`endif

    // Result, accumulator and multiplier registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_s <= '0;
            ovf      <= 1'b0;
            acc      <= '0;
`ifdef ULA_SEQ_MUL_EN
            mcand    <= '0;
            prod     <= '0;
            mplier   <= '0;
            cnt      <= '0;
`endif
        end else begin
`ifdef ULA_SEQ_MUL_EN
            if (accept && op == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, input_a};
                mplier <= input_b;
                prod   <= '0;
                cnt    <= CW'(WIDTH);
            end else if (state == BUSY) begin
                prod   <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                // Last partial product: publish the result as we enter HOLD.
                if (cnt == CW'(1)) begin
                    output_s <= prod_nxt[WIDTH-1:0];
                    ovf      <= |prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
            if (accept && op != OP_MUL) begin
`else
            if (accept) begin
`endif
                output_s <= res;
                ovf      <= res_ovf;
                if (op == OP_ACC) acc <= acc_full[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed plus random checks of ula_seq (WIDTH=4) against an
// integer-arithmetic reference model. Works with or without ULA_SEQ_MUL_EN.
module tb_ula_seq;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] input_a = '0;
    logic [W-1:0] input_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] output_s;
    logic         ovf;
    logic         zero;

    int n_cmp = 0;
    int n_bad = 0;
    int macc  = 0;

    ula_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .input_a(input_a), .input_b(input_b), .out_valid(out_valid),
        .out_ready(out_ready), .output_s(output_s), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on operand values.
    task automatic ref_op(input int o, input int a, input int b,
                          output int s, output int v, output int lat);
        int t, sa, sb;
        lat = 1;
        v   = 0;
        case (o)
            0: begin t = a + b; s = t % M; v = (t >= M); end
            1: begin
                sa = (a >= M/2) ? a - M : a;
                sb = (b >= M/2) ? b - M : b;
                t  = sa - sb;
                s  = (a - b + M) % M;
                v  = (t > M/2 - 1) || (t < -(M/2));
            end
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: begin t = a * (1 << (b % W)); s = t % M; v = (t >= M); end
            6: begin t = macc + a; v = (t >= M); macc = t % M; s = macc; end
            default: begin
`ifdef ULA_SEQ_MUL_EN
                t = a * b; s = t % M; v = (t >= M); lat = W + 1;
`else
                s = 0; v = 1;
`endif
            end
        endcase
    endtask

    // Issue one operation from IDLE, check result and latency, then consume it.
    task automatic issue(input int o, input int a, input int b, input string tag);
        int es, ev, el, lat;
        ref_op(o, a, b, es, ev, el);
        op = 3'(o); input_a = W'(a); input_b = W'(b); in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(el));
        chk({tag, ".s"}, 32'(output_s), 32'(es));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ev));
        chk({tag, ".zero"}, 32'(zero), 32'(es == 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int es, ev, el;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.s", 32'(output_s), 32'd0);
        chk("rst.zero", 32'(zero), 32'd1);
        chk("rst.ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        macc = 0;
        @(posedge clk); #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        issue(0, 3, 1, "add_3_1");
        issue(0, 15, 2, "add_15_2");
        issue(1, 7, 3, "sub_7_3");
        issue(1, 7, 8, "sub_7_8");
        issue(1, 8, 1, "sub_8_1");
        issue(6, 9, 0, "acc_9a");
        issue(2, 12, 10, "and_mid");
        issue(6, 9, 0, "acc_9b");
        issue(5, 11, 2, "shl_11_2");
        issue(7, 5, 3, "mul_5_3");
        issue(7, 6, 7, "mul_6_7");

        // Backpressure: ADD 3+1 held for five cycles.
        op = 3'd0; input_a = 4'd3; input_b = 4'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.s", 32'(output_s), 32'd4);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        op = 3'd4; input_a = 4'd5; input_b = 4'd3; in_valid = 1'b1;
        #1;
        chk("bp.in_ready_rel", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b.out_valid", 32'(out_valid), 32'd1);
        chk("b2b.s", 32'(output_s), 32'd6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Random operations.
        for (int i = 0; i < 60; i++)
            issue(int'($urandom_range(7, 0)), int'($urandom_range(M-1, 0)),
                  int'($urandom_range(M-1, 0)), "rand");

        // Reset during an operation.
        op = 3'd7; input_a = 4'd5; input_b = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        macc = 0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.s", 32'(output_s), 32'd0);
        chk("mrst.zero", 32'(zero), 32'd1);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mrst.idle", 32'(out_valid), 32'd0);
        end
        issue(6, 1, 0, "mrst.acc1");
        ref_op(6, 0, 0, es, ev, el);
        chk("mrst.acc_model", 32'(es), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
